// File: rtl/mult_div_unit.sv
// Multicycle multiply/divide unit holding the architectural HI/LO registers.
// One bit per cycle: shift-add multiply, restoring divide, signed via magnitude + sign fix-up.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_wr,
   input  logic             lo_wr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_FINISH = 2'd2
   } state_t;

   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
      return {WIDTH{1'b0}} - x;
   endfunction

   function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
      return {(2*WIDTH){1'b0}} - x;
   endfunction

   state_t             r_state;
   logic               r_is_div;
   logic               r_neg_q;
   logic               r_neg_r;
   logic               r_dz;
   logic [CW-1:0]      r_cnt;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_opnd;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_busy;
   logic               r_done;
   logic               r_div_zero;

   logic               w_signed;
   logic               w_b_zero;
   logic [WIDTH-1:0]   w_a_mag;
   logic [WIDTH-1:0]   w_b_mag;
   logic [WIDTH:0]     w_mul_sum;
   logic [WIDTH:0]     w_rem_sh;
   logic               w_geq;
   logic [WIDTH-1:0]   w_diff;
   logic [2*WIDTH-1:0] w_acc_next;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rem;

   assign w_signed = ~op[0];
   assign w_b_zero = (b == {WIDTH{1'b0}});
   // The most-negative value negates to itself, which read unsigned is 2^(WIDTH-1).
   assign w_a_mag  = (w_signed && a[WIDTH-1]) ? neg_w(a) : a;
   assign w_b_mag  = (w_signed && b[WIDTH-1]) ? neg_w(b) : b;

   // Multiply keeps {partial product, remaining multiplier bits} in r_acc.
   assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                    + (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});

   // Divide keeps {remainder, dividend shifting into quotient} in r_acc.
   assign w_rem_sh = r_acc[2*WIDTH-1:WIDTH-1];
   assign w_geq    = (w_rem_sh >= {1'b0, r_opnd});
   assign w_diff   = w_rem_sh[WIDTH-1:0] - r_opnd;

   assign w_prod = r_neg_q ? neg_2w(r_acc) : r_acc;
   assign w_quo  = r_neg_q ? neg_w(r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
   assign w_rem  = r_neg_r ? neg_w(r_acc[2*WIDTH-1:WIDTH]) : r_acc[2*WIDTH-1:WIDTH];

   // Next accumulator value for one multiply or divide iteration.
   always_comb begin
      w_acc_next = r_acc;
      if (r_is_div) begin
         if (w_geq) begin
            w_acc_next = {w_diff, r_acc[WIDTH-2:0], 1'b1};
         end else begin
            w_acc_next = {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
         end
      end else begin
         w_acc_next = {w_mul_sum, r_acc[WIDTH-1:1]};
      end
   end

   // Control FSM, datapath registers and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_is_div   <= 1'b0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_dz       <= 1'b0;
         r_cnt      <= {CW{1'b0}};
         r_acc      <= {(2*WIDTH){1'b0}};
         r_opnd     <= {WIDTH{1'b0}};
         r_hi       <= {WIDTH{1'b0}};
         r_lo       <= {WIDTH{1'b0}};
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_div_zero <= 1'b0;
      end else begin
         r_done     <= 1'b0;
         r_div_zero <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_is_div <= op[1];
                  r_neg_q  <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                  r_neg_r  <= w_signed & a[WIDTH-1];
                  r_cnt    <= {CW{1'b0}};
                  r_busy   <= 1'b1;
                  if (op[1]) begin
                     r_acc  <= {{WIDTH{1'b0}}, w_a_mag};
                     r_opnd <= w_b_mag;
                  end else begin
                     r_acc  <= {{WIDTH{1'b0}}, w_b_mag};
                     r_opnd <= w_a_mag;
                  end
                  if (op[1] && w_b_zero) begin
                     r_dz    <= 1'b1;
                     r_state <= S_FINISH;
                  end else begin
                     r_dz    <= 1'b0;
                     r_state <= S_RUN;
                  end
               end else begin
                  if (hi_wr) begin
                     r_hi <= wdata;
                  end else begin
                     r_hi <= r_hi;
                  end
                  if (lo_wr) begin
                     r_lo <= wdata;
                  end else begin
                     r_lo <= r_lo;
                  end
               end
            end
            S_RUN: begin
               r_acc <= w_acc_next;
               if (r_cnt == CW'(WIDTH-1)) begin
                  r_cnt   <= {CW{1'b0}};
                  r_state <= S_FINISH;
               end else begin
                  r_cnt   <= r_cnt + CW'(1);
               end
            end
            S_FINISH: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_state <= S_IDLE;
               if (r_dz) begin
                  r_div_zero <= 1'b1;
               end else if (r_is_div) begin
                  r_hi <= w_rem;
                  r_lo <= w_quo;
               end else begin
                  r_hi <= w_prod[2*WIDTH-1:WIDTH];
                  r_lo <= w_prod[WIDTH-1:0];
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign hi       = r_hi;
   assign lo       = r_lo;
   assign busy     = r_busy;
   assign done     = r_done;
   assign div_zero = r_div_zero;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: a WIDTH=32 and a WIDTH=8 instance on one clock/reset.
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start, hi_wr, lo_wr;
   logic [1:0]  op;
   logic [31:0] a, b, wdata, hi, lo;
   logic        busy, done, div_zero;

   logic        start8, hi_wr8, lo_wr8;
   logic [1:0]  op8;
   logic [7:0]  a8, b8, wdata8, hi8, lo8;
   logic        busy8, done8, div_zero8;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   mult_div_unit #(.WIDTH(32)) u_dut32 (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .hi_wr(hi_wr), .lo_wr(lo_wr), .wdata(wdata), .hi(hi), .lo(lo),
      .busy(busy), .done(done), .div_zero(div_zero)
   );

   mult_div_unit #(.WIDTH(8)) u_dut8 (
      .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
      .hi_wr(hi_wr8), .lo_wr(lo_wr8), .wdata(wdata8), .hi(hi8), .lo(lo8),
      .busy(busy8), .done(done8), .div_zero(div_zero8)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Start an op on the 32-bit unit; inj >= 0 fires a stray start and HI/LO write at that cycle.
   task automatic run32(input string tag, input logic [1:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] ehi, input logic [31:0] elo,
                        input int elat, input logic edz, input int inj);
      logic [31:0] hi0, lo0;
      int lat, bcnt;
      @(negedge clk);
      hi0 = hi; lo0 = lo;
      start = 1'b1; op = o; a = av; b = bv;
      @(negedge clk);
      start = 1'b0; a = 32'hA5A5_5A5A; b = 32'h0F0F_F0F0;
      lat = 0; bcnt = 0;
      while (!done && lat < 100) begin
         if (busy) bcnt++;
         if (lat == 2) begin
            check({tag, " hi hold"}, {32'd0, hi}, {32'd0, hi0});
            check({tag, " lo hold"}, {32'd0, lo}, {32'd0, lo0});
         end
         if (lat == inj) begin
            start = 1'b1; op = 2'b01; a = 32'd7; b = 32'd9;
            hi_wr = 1'b1; lo_wr = 1'b1; wdata = 32'hDEAD_BEEF;
         end else begin
            start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      check({tag, " latency"}, 64'(lat), 64'(elat));
      check({tag, " busy cycles"}, 64'(bcnt), 64'(elat));
      check({tag, " busy in done"}, {63'd0, busy}, 64'd0);
      check({tag, " div_zero"}, {63'd0, div_zero}, {63'd0, edz});
      check({tag, " hi"}, {32'd0, hi}, {32'd0, ehi});
      check({tag, " lo"}, {32'd0, lo}, {32'd0, elo});
      @(negedge clk);
      check({tag, " done width"}, {62'd0, done, div_zero}, 64'd0);
   endtask

   task automatic run8(input string tag, input logic [1:0] o, input logic [7:0] av,
                       input logic [7:0] bv, input logic [7:0] ehi, input logic [7:0] elo);
      int lat;
      @(negedge clk);
      start8 = 1'b1; op8 = o; a8 = av; b8 = bv;
      @(negedge clk);
      start8 = 1'b0; a8 = 8'h3C; b8 = 8'hC3;
      lat = 0;
      while (!done8 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check({tag, " latency"}, 64'(lat), 64'd9);
      check({tag, " hi"}, {56'd0, hi8}, {56'd0, ehi});
      check({tag, " lo"}, {56'd0, lo8}, {56'd0, elo});
   endtask

   task automatic write_hilo(input logic sel_hi, input logic [31:0] v);
      @(negedge clk);
      hi_wr = sel_hi; lo_wr = ~sel_hi; wdata = v;
      @(negedge clk);
      hi_wr = 1'b0; lo_wr = 1'b0;
      check(sel_hi ? "mthi" : "mtlo", {32'd0, sel_hi ? hi : lo}, {32'd0, v});
   endtask

   initial begin
      int dcnt;
      reset = 1'b0;
      start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0; op = 2'b00;
      a = 32'd0; b = 32'd0; wdata = 32'd0;
      start8 = 1'b0; hi_wr8 = 1'b0; lo_wr8 = 1'b0; op8 = 2'b00;
      a8 = 8'd0; b8 = 8'd0; wdata8 = 8'd0;
      #12;
      check("reset hi/lo", {hi, lo}, 64'd0);
      check("reset flags", {61'd0, busy, done, div_zero}, 64'd0);
      @(negedge clk);
      reset = 1'b1;

      run32("mult -3x5",   2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 33, 1'b0, -1);
      run32("multu ff^2",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, 1'b0, -1);
      run32("mult max*min", 2'b00, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, 33, 1'b0, -1);
      run32("div -7/2",    2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 1'b0, -1);
      run32("divu 7/2",    2'b11, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 33, 1'b0, -1);
      run32("div min/-1",  2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33, 1'b0, -1);
      run32("div 7/-2",    2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33, 1'b0, -1);

      write_hilo(1'b1, 32'h1234_5678);
      write_hilo(1'b0, 32'h9ABC_DEF0);
      run32("divu by 0",   2'b11, 32'h0000_0005, 32'h0000_0000, 32'h1234_5678, 32'h9ABC_DEF0, 1, 1'b1, -1);
      run32("div by 0",    2'b10, 32'hFFFF_FFFF, 32'h0000_0000, 32'h1234_5678, 32'h9ABC_DEF0, 1, 1'b1, -1);
      run32("ignored ins", 2'b01, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F, 33, 1'b0, 5);

      // Abort a MULT with reset 10 cycles in; nothing may complete afterwards.
      @(negedge clk);
      start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd5;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b0;
      #1;
      check("abort hi/lo", {hi, lo}, 64'd0);
      check("abort busy", {63'd0, busy}, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      dcnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) dcnt++;
      end
      check("abort no done", 64'(dcnt), 64'd0);

      run8("w8 mult 80x80", 2'b00, 8'h80, 8'h80, 8'h40, 8'h00);
      run8("w8 div 80/ff",  2'b10, 8'h80, 8'hFF, 8'h00, 8'h80);
      run8("w8 multu ff^2", 2'b01, 8'hFF, 8'hFF, 8'hFE, 8'h01);
      run8("w8 divu c8/0d", 2'b11, 8'hC8, 8'h0D, 8'h05, 8'h0F);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

- Parametrised multicycle multiply/divide unit for the multicycle CPU.
- Holds the architectural HI and LO registers and is fed from the A and B register outputs.
- HI and LO are read back into the register-data write mux.
- Iterates one bit per cycle (shift-add multiply, restoring divide) over a configurable operand width, handles signed and unsigned modes, and lets the control unit write HI/LO directly.

## Interface
- WIDTH, 32, operand/HI/LO width in bits; legal values are 4 or more.
- clk  in  1  system clock; everything is updated on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  one-cycle request to begin an operation; sampled only in IDLE.
- op  in  2  operation select: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- a  in  WIDTH  multiplicand / dividend; captured on the start edge.
- b  in  WIDTH  multiplier / divisor; captured on the start edge.
- hi_wr  in  1  write wdata into HI (MTHI).
- lo_wr  in  1  write wdata into LO (MTLO).
- wdata  in  WIDTH  data for hi_wr / lo_wr.
- hi  out  WIDTH  HI register: upper product half, or remainder.
- lo  out  WIDTH  LO register: lower product half, or quotient.
- busy  out  1  an operation is in progress.
- done  out  1  one-cycle pulse when an operation completes.
- div_zero  out  1  one-cycle pulse, together with done, when a DIV/DIVU has b = 0.

## Operation
- FSM states:
  - IDLE: accepts start and hi_wr/lo_wr.
  - RUN: iterating; an internal counter runs 0..WIDTH-1.
  - FINISH: sign fix-up, HI/LO commit, done pulse.
- IDLE with start = 1:
  - Latches op.
  - Latches |a| and |b| as magnitudes; magnitudes are used only for signed ops, and the most-negative value maps to 2^(WIDTH-1) unsigned.
  - Latches the result sign flags.
  - Counter ← 0, then → RUN.
- IDLE with start = 1, divide op, b = 0: → FINISH directly with the divide-by-zero flag set; no iteration.
- RUN, multiply: 2·WIDTH-bit accumulator; each cycle, if the current multiplier LSB is 1 add the multiplicand at the proper alignment, then shift. WIDTH iterations.
- RUN, divide: restoring division. Each cycle shift remainder:dividend left by 1 and trial-subtract the divisor; if the result is non-negative, keep it and set the quotient bit. WIDTH iterations.
- RUN → FINISH when the counter reaches WIDTH-1.
- FINISH, signed multiply: negate the 2·WIDTH product (two's complement) if sign(a) ≠ sign(b); hi:lo ← product.
- FINISH, signed divide:
  - Quotient is negated if signs differ; it truncates toward zero.
  - Remainder takes the sign of the dividend.
  - lo ← quotient, hi ← remainder, all taken mod 2^WIDTH.
  - MIN / −1 yields lo = MIN, hi = 0, with no flag.
- FINISH, divide by zero: hi and lo unchanged, div_zero = 1.
- FINISH always goes → IDLE.
- hi_wr/lo_wr:
  - Honoured only in IDLE with start = 0; both may be asserted in the same cycle.
  - Ignored while busy and in any cycle where start = 1.
- start outside IDLE is ignored, with no queuing.
- Operand inputs a/b may change freely after the start edge.

## Timing
- Reset (async assert, release synchronous to the next edge) clears:
  - hi and lo to 0;
  - busy, done and div_zero to 0;
  - state to IDLE and the counter to 0.
- Reset asserted mid-operation aborts immediately; no done pulse follows.
- With start sampled at edge k:
  - busy = 1 from after edge k through edge k+WIDTH+1.
  - FINISH is registered at edge k+WIDTH; hi/lo are updated and done = 1 after edge k+WIDTH+1.
  - Total latency is WIDTH+1 cycles from the start edge to the done-high cycle.
- Divide by zero: done = div_zero = 1 after edge k+1, and busy is high only for the cycle after edge k.
- done and div_zero are high for exactly one cycle; busy is 0 during the done cycle, so a new start may be given in the done cycle.
- hi/lo change only at the completion edge, on a direct write, or on reset. They are stable throughout RUN and keep the previous result.
- Direct write (hi_wr/lo_wr): the value is visible on hi/lo the cycle after the write edge.

## Test plan
- **MULT, −3 × 5 (WIDTH = 32):** a = FFFFFFFD, b = 00000005, start at edge k → done after edge k+33; hi = FFFFFFFF, lo = FFFFFFF1; busy high for 33 cycles.
- **MULTU, all-ones squared:** a = b = FFFFFFFF → hi = FFFFFFFE, lo = 00000001.
- **DIV and DIVU, 7 by 2:**
  - DIV a = FFFFFFF9 (−7), b = 2 → lo = FFFFFFFD (−3), hi = FFFFFFFF (−1).
  - DIVU a = 7, b = 2 → lo = 3, hi = 1.
  - DIV a = 80000000, b = FFFFFFFF → lo = 80000000, hi = 0.
- **Divide by zero:** preload hi = 12345678, lo = 9ABCDEF0 via hi_wr/lo_wr; DIVU with b = 0 → done and div_zero high the cycle after edge k+1; hi/lo unchanged.
- **Reset abort and ignored inputs:**
  - Assert reset 10 cycles into a MULT → hi = lo = 0 and busy = 0 immediately; no done afterwards.
  - In a separate run, a second start and a hi_wr at cycle 5 of a MULT are ignored; the result matches the first operands.
- **WIDTH = 8 instance:**
  - MULT 0x80 × 0x80 → hi = 0x40, lo = 0x00, done after edge k+9.
  - DIV 0x80 / 0xFF → lo = 0x80, hi = 0x00.
